// File: rtl/mod_ctrl_pkg.sv
// Shared types and widths for the modulus issue controller.
// Holds the FSM encoding, the counter widths and the settle-counter preload helper.
package mod_ctrl_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int OPCNT_W      = 16;
  localparam int ERRCNT_W     = 8;
  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Capture happens on the edge where the count is already 0, hence the -1.
  function automatic logic [SETTLE_CNT_W-1:0] settle_load(input int settle);
    return SETTLE_CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; async clear on rst.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mod_issue_ctrl.sv
// Issue/capture sequencer around the combinational modulus stage: holds operands
// for SETTLE cycles, captures a sign-extended remainder and keeps op/error counts.
module mod_issue_ctrl
  import mod_ctrl_pkg::*;
#(
  parameter int                 WIDTH      = DEF_WIDTH,
  parameter int                 SETTLE     = 2,
  parameter logic [OPCNT_W-1:0] OPCNT_INIT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_num,
  input  logic [WIDTH-1:0]     in_den,
  output logic [WIDTH-1:0]     mod_num,
  output logic [WIDTH-1:0]     mod_den,
  input  logic [2*WIDTH-1:0]   mod_result,
  input  logic                 mod_error,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 out_error,
  output logic [OPCNT_W-1:0]   op_count,
  output logic [ERRCNT_W-1:0]  err_count,
  output logic                 busy
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE);

  state_t                  state_reg;
  logic [SETTLE_CNT_W-1:0] settle_cnt_reg;
  logic                    capture;
  logic [2*WIDTH-1:0]      ext_result;
  logic                    unused_upper;

  // Only the low half of the stage output is meaningful; the rest is discarded.
  assign unused_upper = ^mod_result[2*WIDTH-1:WIDTH];

  genvar gi;
  for (gi = 0; gi < 2*WIDTH; gi++) begin : g_ext
    if (gi < WIDTH) begin : g_low
      assign ext_result[gi] = mod_result[gi];
    end else begin : g_high
      assign ext_result[gi] = mod_result[WIDTH-1];
    end
  end

  assign capture  = (state_reg == S_SETTLE) && (settle_cnt_reg == '0);
  // Combinational from out_ready so a drained result frees the slot in the same cycle.
  assign in_ready = (state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      settle_cnt_reg <= '0;
      mod_num        <= '0;
      mod_den        <= '0;
      out_result     <= '0;
      out_error      <= 1'b0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            mod_num        <= in_num;
            mod_den        <= in_den;
            settle_cnt_reg <= SETTLE_LOAD;
            state_reg      <= S_SETTLE;
            busy           <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_reg == '0) begin
            out_result <= mod_error ? '0 : ext_result;
            out_error  <= mod_error;
            out_valid  <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              mod_num        <= in_num;
              mod_den        <= in_den;
              settle_cnt_reg <= SETTLE_LOAD;
              state_reg      <= S_SETTLE;
            end else begin
              state_reg <= S_IDLE;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Wraps naturally at the register width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= OPCNT_INIT;
    end else if (capture) begin
      op_count <= op_count + 1'b1;
    end
  end

  sat_counter #(
    .W(ERRCNT_W)
  ) u_err_count (
    .clk  (clk),
    .rst  (rst),
    .inc  (capture & mod_error),
    .count(err_count)
  );

endmodule

// File: tb/tb_mod_issue_ctrl.sv
// Directed bench for mod_issue_ctrl with a behavioural modulus stage beside each instance.
module tb_mod_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_num = 16'h0;
  logic [15:0] in_den = 16'h0;
  logic [15:0] mod_num, mod_den;
  logic [31:0] mod_result;
  logic        mod_error;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_error;
  logic [15:0] op_count;
  logic [7:0]  err_count;
  logic        busy;
  logic [15:0] upper_inj = 16'h0;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [15:0] w_in_num = 16'h0;
  logic [15:0] w_in_den = 16'h0;
  logic [15:0] w_mod_num, w_mod_den;
  logic [31:0] w_mod_result;
  logic        w_mod_error;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [31:0] w_out_result;
  logic        w_out_error;
  logic [15:0] w_op_count;
  logic [7:0]  w_err_count;
  logic        w_busy;

  int checks = 0;
  int errors = 0;
  int txn = 0;

  always #5 clk = ~clk;

  // Modulus stage model: low half is the remainder, upper half is injected junk.
  always_comb begin
    mod_error  = (mod_den == 16'h0);
    mod_result = {upper_inj, 16'h0};
    if (mod_den != 16'h0) mod_result = {upper_inj, mod_num % mod_den};
  end

  always_comb begin
    w_mod_error  = (w_mod_den == 16'h0);
    w_mod_result = 32'h0;
    if (w_mod_den != 16'h0) w_mod_result = {16'h0, w_mod_num % w_mod_den};
  end

  mod_issue_ctrl #(.WIDTH(16), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_num(in_num), .in_den(in_den), .mod_num(mod_num), .mod_den(mod_den),
    .mod_result(mod_result), .mod_error(mod_error), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_error(out_error),
    .op_count(op_count), .err_count(err_count), .busy(busy)
  );

  mod_issue_ctrl #(.WIDTH(16), .SETTLE(1), .OPCNT_INIT(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_num(w_in_num), .in_den(w_in_den), .mod_num(w_mod_num), .mod_den(w_mod_den),
    .mod_result(w_mod_result), .mod_error(w_mod_error), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_result(w_out_result), .out_error(w_out_error),
    .op_count(w_op_count), .err_count(w_err_count), .busy(w_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair from IDLE and wait the SETTLE=2 capture latency.
  task automatic issue_op(input logic [15:0] num, input logic [15:0] den);
    in_num   = num;
    in_den   = den;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_num   = 16'hBEEF;
    in_den   = 16'h0003;
    tick();
    tick();
  endtask

  task automatic consume();
    txn++;
    $display("txn %0d: num=%h den=%h result=%h err=%b op_count=%0d err_count=%0d",
             txn, mod_num, mod_den, out_result, out_error, op_count, err_count);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got %h exp 00000000", out_result); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL reset_out_error got %b exp 0", out_error); end
    checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count got %h exp 0000", op_count); end
    checks++; if (err_count !== 8'h0) begin errors++; $display("FAIL reset_err_count got %h exp 00", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({mod_num, mod_den} !== 32'h0) begin errors++; $display("FAIL reset_mod_ops got %h exp 00000000", {mod_num, mod_den}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    upper_inj = 16'h0;
    in_num    = 16'h000F;
    in_den    = 16'h0002;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    in_num   = 16'hBEEF;
    in_den   = 16'h0007;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n1 got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    checks++; if ({mod_num, mod_den} !== 32'h000F0002) begin errors++; $display("FAIL basic_latch got %h exp 000F0002", {mod_num, mod_den}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n2 got %b exp 0", out_valid); end
    checks++; if ({mod_num, mod_den} !== 32'h000F0002) begin errors++; $display("FAIL basic_frozen got %h exp 000F0002", {mod_num, mod_den}); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    checks++; if (out_result !== 32'h00000001) begin errors++; $display("FAIL basic_result got %h exp 00000001", out_result); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL basic_error got %b exp 0", out_error); end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL basic_op_count got %0d exp 1", op_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got %b exp 0", in_ready); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_drain_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_drain_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_div_zero();
    upper_inj = 16'hDEAD;
    issue_op(16'h000F, 16'h0000);
    checks++; if (out_error !== 1'b1) begin errors++; $display("FAIL dz_error got %b exp 1", out_error); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL dz_result got %h exp 00000000", out_result); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL dz_err_count got %0d exp 1", err_count); end
    checks++; if (op_count !== 16'd2) begin errors++; $display("FAIL dz_op_count got %0d exp 2", op_count); end
    consume();
    issue_op(16'h000F, 16'h0002);
    checks++; if (out_result !== 32'h00000001) begin errors++; $display("FAIL garbage_result got %h exp 00000001", out_result); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL garbage_error got %b exp 0", out_error); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL garbage_err_count got %0d exp 1", err_count); end
    consume();
  endtask

  task automatic test_sign_ext();
    upper_inj = 16'h0000;
    issue_op(16'h9000, 16'hA000);
    checks++; if (out_result !== 32'hFFFF9000) begin errors++; $display("FAIL sext_neg got %h exp FFFF9000", out_result); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL sext_error got %b exp 0", out_error); end
    consume();
    upper_inj = 16'hFFFF;
    issue_op(16'h7FFF, 16'h8000);
    checks++; if (out_result !== 32'h00007FFF) begin errors++; $display("FAIL sext_pos got %h exp 00007FFF", out_result); end
    checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL sext_op_count got %0d exp 5", op_count); end
    consume();
  endtask

  task automatic test_backpressure();
    upper_inj = 16'h0;
    issue_op(16'h0011, 16'h0005);
    checks++; if (out_result !== 32'h00000002) begin errors++; $display("FAIL bp_first got %h exp 00000002", out_result); end
    in_num   = 16'h0064;
    in_den   = 16'h0009;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_result !== 32'h00000002) begin errors++; $display("FAIL bp_hold[%0d] got %h exp 00000002", i, out_result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      checks++; if (mod_num !== 16'h0011) begin errors++; $display("FAIL bp_no_latch[%0d] got %h exp 0011", i, mod_num); end
    end
    checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL bp_op_count got %0d exp 6", op_count); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    txn++;
    $display("txn %0d: num=%h den=%h result=%h err=%b (overlapped accept)", txn, mod_num, mod_den, out_result, out_error);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_overlap_valid got %b exp 0", out_valid); end
    checks++; if ({mod_num, mod_den} !== 32'h00640009) begin errors++; $display("FAIL bp_overlap_latch got %h exp 00640009", {mod_num, mod_den}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_overlap_busy got %b exp 1", busy); end
    tick();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b exp 1", out_valid); end
    checks++; if (out_result !== 32'h00000001) begin errors++; $display("FAIL bp_second_result got %h exp 00000001", out_result); end
    checks++; if (op_count !== 16'd7) begin errors++; $display("FAIL bp_second_op_count got %0d exp 7", op_count); end
    consume();
  endtask

  task automatic test_reset_mid();
    upper_inj = 16'h0;
    in_num    = 16'h000F;
    in_den    = 16'h0002;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if ({mod_num, mod_den} !== 32'h0) begin errors++; $display("FAIL rmid_mod_ops got %h exp 00000000", {mod_num, mod_den}); end
    checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL rmid_op_count got %0d exp 0", op_count); end
    checks++; if (err_count !== 8'h0) begin errors++; $display("FAIL rmid_err_count got %0d exp 0", err_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_result got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle_busy got %b exp 0", busy); end
    issue_op(16'h000F, 16'h0002);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_next_valid got %b exp 1", out_valid); end
    checks++; if (out_result !== 32'h00000001) begin errors++; $display("FAIL rmid_next_result got %h exp 00000001", out_result); end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rmid_next_op_count got %0d exp 1", op_count); end
    consume();
  endtask

  task automatic test_err_sat();
    upper_inj = 16'h0;
    for (int i = 0; i < 260; i++) begin
      issue_op(16'(i), 16'h0000);
      if (i == 253) begin
        checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL sat_err_254 got %0d exp 254", err_count); end
      end
      if (i == 254) begin
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_255 got %0d exp 255", err_count); end
      end
      consume();
    end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_hold got %0d exp 255", err_count); end
    checks++; if (op_count !== 16'd261) begin errors++; $display("FAIL sat_op_count got %0d exp 261", op_count); end
  endtask

  task automatic test_op_wrap();
    checks++; if (w_op_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload got %h exp FFFE", w_op_count); end
    w_in_num   = 16'h000F;
    w_in_den   = 16'h0004;
    w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_latency got %b exp 0", w_out_valid); end
    tick();
    checks++; if (w_out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid1 got %b exp 1", w_out_valid); end
    checks++; if (w_out_result !== 32'h00000003) begin errors++; $display("FAIL wrap_result1 got %h exp 00000003", w_out_result); end
    checks++; if (w_op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_op_ffff got %h exp FFFF", w_op_count); end
    txn++;
    $display("txn %0d: wrap inst result=%h op_count=%h", txn, w_out_result, w_op_count);
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
    checks++; if (w_out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain got %b exp 0", w_out_valid); end
    w_in_num   = 16'h0008;
    w_in_den   = 16'h0003;
    w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    tick();
    checks++; if (w_out_result !== 32'h00000002) begin errors++; $display("FAIL wrap_result2 got %h exp 00000002", w_out_result); end
    checks++; if (w_op_count !== 16'h0000) begin errors++; $display("FAIL wrap_op_zero got %h exp 0000", w_op_count); end
    txn++;
    $display("txn %0d: wrap inst result=%h op_count=%h", txn, w_out_result, w_op_count);
    w_out_ready = 1'b1;
    tick();
    w_out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_sign_ext();
    test_backpressure();
    test_reset_mid();
    test_err_sat();
    test_op_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
